// File: rtl/tdc_phase_det_if.sv
// rtl/tdc_phase_det_if.sv - phase error result bundle from the TDC phase detector
interface tdc_phase_det_if #(
    parameter int CNT_W = 5
) ();
    logic [CNT_W-1:0] err_mag;
    logic             err_sign;
    logic             err_valid;
    logic             locked;

    modport master (
        output err_mag,
        output err_sign,
        output err_valid,
        output locked
    );

    modport slave (
        input err_mag,
        input err_sign,
        input err_valid,
        input locked
    );
endinterface

// File: rtl/tdc_phase_det.sv
// rtl/tdc_phase_det.sv - counter-based ref/fb phase detector with lock flag
module tdc_phase_det #(
    parameter int CNT_W       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_COUNT  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             ref_in,
    input  logic             fb_in,
    tdc_phase_det_if.master  res
);
    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam logic [CNT_W-1:0] TOL    = CNT_W'(LOCK_TOL);
    localparam int               LK_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [LK_W-1:0]  LK_MAX = LK_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FB  = 2'd1,
        WAIT_REF = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] ref_sync;
    logic [SYNC_STAGES-1:0] fb_sync;
    logic                   ref_d;
    logic                   fb_d;
    logic                   r_edge;
    logic                   f_edge;

    state_t                 state;
    state_t                 state_n;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   emit;
    logic [CNT_W-1:0]       emit_mag;
    logic                   emit_sign;
    logic [LK_W-1:0]        lk;
    logic [LK_W-1:0]        lk_next;

    // Synchronize both async inputs and keep one delayed copy for edge detection;
    // runs regardless of ena so re-enabling never sees a stale transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_sync <= '0;
            fb_sync  <= '0;
            ref_d    <= 1'b0;
            fb_d     <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
            fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
            ref_d    <= ref_sync[SYNC_STAGES-1];
            fb_d     <= fb_sync[SYNC_STAGES-1];
        end
    end

    assign r_edge  = ref_sync[SYNC_STAGES-1] & ~ref_d;
    assign f_edge  = fb_sync[SYNC_STAGES-1] & ~fb_d;
    assign cnt_inc = (cnt == MAX) ? MAX : cnt + 1'b1;
    assign lk_next = (lk == LK_MAX) ? LK_MAX : lk + 1'b1;

    // Measurement FSM state and saturating distance counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and emit decision: the closing edge reports cnt+1 cycles of distance,
    // a repeated opening edge reports a slip at MAX and restarts the measurement.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        emit      = 1'b0;
        emit_mag  = '0;
        emit_sign = 1'b0;
        if (!ena) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (r_edge && f_edge) begin
                        emit = 1'b1;
                    end else if (r_edge) begin
                        state_n = WAIT_FB;
                    end else if (f_edge) begin
                        state_n = WAIT_REF;
                    end
                end
                WAIT_FB: begin
                    if (f_edge) begin
                        emit     = 1'b1;
                        emit_mag = cnt_inc;
                        state_n  = IDLE;
                        cnt_n    = '0;
                    end else if (r_edge) begin
                        emit     = 1'b1;
                        emit_mag = MAX;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                WAIT_REF: begin
                    emit_sign = 1'b1;
                    if (r_edge) begin
                        emit     = 1'b1;
                        emit_mag = cnt_inc;
                        state_n  = IDLE;
                        cnt_n    = '0;
                    end else if (f_edge) begin
                        emit     = 1'b1;
                        emit_mag = MAX;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Register the emitted error and track the run of in-tolerance measurements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res.err_mag   <= '0;
            res.err_sign  <= 1'b0;
            res.err_valid <= 1'b0;
            res.locked    <= 1'b0;
            lk            <= '0;
        end else begin
            res.err_valid <= emit;
            if (emit) begin
                res.err_mag  <= emit_mag;
                res.err_sign <= emit_sign;
                if (emit_mag <= TOL) begin
                    lk         <= lk_next;
                    res.locked <= (lk_next == LK_MAX);
                end else begin
                    lk         <= '0;
                    res.locked <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_tdc_phase_det.sv
// tb/tb_tdc_phase_det.sv - self-checking bench for tdc_phase_det
module tb_tdc_phase_det;
    localparam int CNT_W      = 5;
    localparam int MAX        = 31;
    localparam int LOCK_TOL   = 1;
    localparam int LOCK_COUNT = 8;

    typedef struct {
        int mag;
        int sign;
        int lck;
    } emit_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic ena    = 1'b0;
    logic ref_in = 1'b0;
    logic fb_in  = 1'b0;

    int    checks    = 0;
    int    failures  = 0;
    int    lk_model  = 0;
    int    hold_mag  = 0;
    int    hold_sign = 0;
    int    hold_lck  = 0;
    emit_t seen[$];
    emit_t mon_e;

    tdc_phase_det_if #(.CNT_W(CNT_W)) res_if ();

    tdc_phase_det #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .LOCK_TOL   (LOCK_TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .ref_in(ref_in),
        .fb_in (fb_in),
        .res   (res_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (res_if.err_valid === 1'b1) begin
            mon_e.mag  = int'(res_if.err_mag);
            mon_e.sign = int'(res_if.err_sign);
            mon_e.lck  = int'(res_if.locked);
            seen.push_back(mon_e);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_emit(input string tag, input int exp_mag, input int exp_sign);
        emit_t e;
        int    exp_lck;
        if (exp_mag <= LOCK_TOL) lk_model = (lk_model < LOCK_COUNT) ? lk_model + 1 : LOCK_COUNT;
        else lk_model = 0;
        exp_lck   = (lk_model == LOCK_COUNT) ? 1 : 0;
        hold_mag  = exp_mag;
        hold_sign = exp_sign;
        hold_lck  = exp_lck;
        check({tag, ".present"}, (seen.size() > 0) ? 1 : 0, 1);
        if (seen.size() > 0) begin
            e = seen.pop_front();
            check({tag, ".mag"}, e.mag, exp_mag);
            check({tag, ".sign"}, e.sign, exp_sign);
            check({tag, ".locked"}, e.lck, exp_lck);
        end
    endtask

    task automatic expect_none(input string tag);
        check({tag, ".extra_pulses"}, seen.size(), 0);
        seen.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_meas(input string tag, input int gap, input bit fb_first);
        int exp_mag;
        int exp_sign;
        wait_cycles(1);
        if (gap == 0) begin
            ref_in = 1'b1;
            fb_in  = 1'b1;
        end else if (fb_first) begin
            fb_in = 1'b1;
        end else begin
            ref_in = 1'b1;
        end
        wait_cycles(gap);
        ref_in = 1'b1;
        fb_in  = 1'b1;
        wait_cycles(2);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        wait_cycles(8);
        exp_mag  = (gap > MAX) ? MAX : gap;
        exp_sign = (gap != 0 && fb_first) ? 1 : 0;
        expect_emit(tag, exp_mag, exp_sign);
        expect_none(tag);
    endtask

    initial begin
        ena   = 1'b1;
        rst_n = 1'b0;
        wait_cycles(3);
        check("reset.err_mag", int'(res_if.err_mag), 0);
        check("reset.err_sign", int'(res_if.err_sign), 0);
        check("reset.err_valid", int'(res_if.err_valid), 0);
        check("reset.locked", int'(res_if.locked), 0);
        rst_n = 1'b1;
        wait_cycles(4);
        expect_none("reset");

        run_meas("fb_lag7", 7, 1'b0);
        run_meas("fb_lead3", 3, 1'b1);
        run_meas("same_cycle", 0, 1'b0);
        run_meas("fb_lag50_sat", 50, 1'b0);

        ref_in = 1'b1;
        wait_cycles(3);
        ref_in = 1'b0;
        wait_cycles(7);
        ref_in = 1'b1;
        wait_cycles(4);
        fb_in = 1'b1;
        wait_cycles(2);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        wait_cycles(8);
        expect_emit("slip", MAX, 0);
        expect_emit("after_slip", 4, 0);
        expect_none("slip");

        for (int i = 0; i < LOCK_COUNT; i++) begin
            run_meas($sformatf("lock_run%0d", i), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("lock.locked_after_run", int'(res_if.locked), 1);
        run_meas("lock_break", 5, 1'b0);
        wait_cycles(10);
        check("lock.mag_holds", int'(res_if.err_mag), 5);
        check("lock.unlocked", int'(res_if.locked), 0);

        for (int i = 0; i < 12; i++) begin
            run_meas($sformatf("rand%0d", i), int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
        end

        ref_in = 1'b1;
        wait_cycles(3);
        ref_in = 1'b0;
        wait_cycles(10);
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        lk_model  = 0;
        hold_mag  = 0;
        hold_sign = 0;
        hold_lck  = 0;
        check("midreset.err_mag", int'(res_if.err_mag), 0);
        check("midreset.err_sign", int'(res_if.err_sign), 0);
        check("midreset.err_valid", int'(res_if.err_valid), 0);
        check("midreset.locked", int'(res_if.locked), 0);
        wait_cycles(6);
        expect_none("midreset");
        fb_in = 1'b1;
        wait_cycles(2);
        ref_in = 1'b1;
        wait_cycles(2);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        wait_cycles(8);
        expect_emit("midreset_fb_first", 2, 1);
        expect_none("midreset_fb_first");

        ena = 1'b0;
        wait_cycles(2);
        ref_in = 1'b1;
        wait_cycles(4);
        fb_in = 1'b1;
        wait_cycles(4);
        ref_in = 1'b0;
        wait_cycles(2);
        ref_in = 1'b1;
        wait_cycles(2);
        fb_in = 1'b0;
        wait_cycles(2);
        ref_in = 1'b0;
        wait_cycles(4);
        ena = 1'b1;
        wait_cycles(8);
        expect_none("ena_off");
        check("ena_off.err_mag_hold", int'(res_if.err_mag), hold_mag);
        check("ena_off.err_sign_hold", int'(res_if.err_sign), hold_sign);
        check("ena_off.locked_hold", int'(res_if.locked), hold_lck);
        run_meas("post_ena", 6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
